// File: rtl/task1_pkg.sv
// Shared definitions for the task1 feeder.
// Contents: default operand width, FSM state encoding, operand slot indices.
package task1_pkg;

   localparam int unsigned DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESULT  = 2'd3
   } state_t;

   // Slot index of each operand register within one 4-word group
   localparam logic [1:0] IDX_A = 2'd0;
   localparam logic [1:0] IDX_B = 2'd1;
   localparam logic [1:0] IDX_C = 2'd2;
   localparam logic [1:0] IDX_D = 2'd3;

endpackage

// File: rtl/task1_feeder_if.sv
// Bus bundle between the feeder and its environment.
// Operand stream : s_data, s_valid (to feeder), s_ready (from feeder)
// task1 side     : in_val, a, b, c, d (from feeder), Q, out_val (to feeder)
// Result stream  : r_data, r_valid (from feeder), r_ready (to feeder)
// Status         : timeout (from feeder)
// master = feeder view, slave = environment view.
interface task1_feeder_if
   import task1_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);

   logic signed [WIDTH-1:0] s_data;
   logic                    s_valid;
   logic                    s_ready;

   logic                    in_val;
   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic signed [WIDTH-1:0] c;
   logic signed [WIDTH-1:0] d;
   logic signed [WIDTH-1:0] Q;
   logic                    out_val;

   logic signed [WIDTH-1:0] r_data;
   logic                    r_valid;
   logic                    r_ready;

   logic                    timeout;

   modport master (
      input  s_data, s_valid, Q, out_val, r_ready,
      output s_ready, in_val, a, b, c, d, r_data, r_valid, timeout
   );

   modport slave (
      output s_data, s_valid, Q, out_val, r_ready,
      input  s_ready, in_val, a, b, c, d, r_data, r_valid, timeout
   );

endinterface

// File: rtl/task1_feeder.sv
// Sequencer in front of task1: packs four streamed operand words into a..d,
// fires a one-cycle in_val, waits (with a watchdog) for out_val, and offers
// the captured Q on a valid/ready result port. One operation in flight.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   bus     - task1_feeder_if.master (operand stream, task1 link, result
//             stream, timeout pulse)
// Parameters: WIDTH (operand/result width), TIMEOUT (WAIT cycles before abort, >= 1)
module task1_feeder
   import task1_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   task1_feeder_if.master bus
);

   localparam int unsigned     CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   WD_LAST = CW'(TIMEOUT - 1);

   state_t                  state_q, state_d;
   logic [1:0]              idx_q, idx_d;
   logic signed [WIDTH-1:0] a_q, a_d;
   logic signed [WIDTH-1:0] b_q, b_d;
   logic signed [WIDTH-1:0] c_q, c_d;
   logic signed [WIDTH-1:0] d_q, d_d;
   logic signed [WIDTH-1:0] rdata_q, rdata_d;
   logic [CW-1:0]           wd_q, wd_d;
   logic                    ready_q, ready_d;
   logic                    timeout_q, timeout_d;

   logic                    accept;
   logic                    wd_expire;

   // ready_q mirrors "state is COLLECT" but is 0 while in reset, so the
   // handshake qualifier never combines rst into an output path.
   assign accept    = ready_q && bus.s_valid;
   // out_val has priority over the final watchdog cycle
   assign wd_expire = (state_q == WAIT) && !bus.out_val && (wd_q == WD_LAST);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT: if (accept && (idx_q == IDX_D)) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT: begin
            if (bus.out_val)    state_d = RESULT;
            else if (wd_expire) state_d = COLLECT;
         end
         RESULT:  if (bus.r_ready) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      bus.s_ready = ready_q;
      bus.in_val  = (state_q == ISSUE);
      bus.r_valid = (state_q == RESULT);
      bus.r_data  = rdata_q;
      bus.a       = a_q;
      bus.b       = b_q;
      bus.c       = c_q;
      bus.d       = d_q;
      bus.timeout = timeout_q;
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      d_d       = d_q;
      rdata_d   = rdata_q;
      wd_d      = wd_q;
      ready_d   = (state_d == COLLECT);
      timeout_d = wd_expire;

      if (accept) begin
         unique case (idx_q)
            IDX_A:   a_d = bus.s_data;
            IDX_B:   b_d = bus.s_data;
            IDX_C:   c_d = bus.s_data;
            default: d_d = bus.s_data;
         endcase
         idx_d = idx_q + 2'd1;  // wraps to IDX_A after the 4th word
      end

      if (state_q == ISSUE) begin
         wd_d = '0;
      end else if (state_q == WAIT) begin
         wd_d = wd_q + 1'b1;
         if (bus.out_val) rdata_d = bus.Q;
      end

      if (wd_expire) idx_d = IDX_A;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= IDX_A;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
         rdata_q   <= '0;
         wd_q      <= '0;
         ready_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         d_q       <= d_d;
         rdata_q   <= rdata_d;
         wd_q      <= wd_d;
         ready_q   <= ready_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_task1_feeder.sv
// Directed self-checking bench for task1_feeder (TIMEOUT = 8, WIDTH = 16).
// The bench plays the task1 stub and the result consumer itself.
module tb_task1_feeder;

   localparam int unsigned W  = 16;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   task1_feeder_if #(.WIDTH(W)) bus ();

   task1_feeder #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int inval_cnt = 0;
   int tmo_cnt   = 0;
   int c0;

   always @(posedge clk) begin
      if (bus.in_val === 1'b1)  inval_cnt <= inval_cnt + 1;
      if (bus.timeout === 1'b1) tmo_cnt   <= tmo_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Streams four words with s_valid held; returns in the ISSUE cycle.
   task automatic send4(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3);
      logic [15:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < 4; i++) begin
         bus.s_data  = w[i];
         bus.s_valid = 1'b1;
         tick();
      end
      bus.s_valid = 1'b0;
      check_eq({tag, "_in_val"},  16'(bus.in_val),  16'd1);
      check_eq({tag, "_s_ready"}, 16'(bus.s_ready), 16'd0);
      check_eq({tag, "_a"}, bus.a, w0);
      check_eq({tag, "_b"}, bus.b, w1);
      check_eq({tag, "_c"}, bus.c, w2);
      check_eq({tag, "_d"}, bus.d, w3);
   endtask

   // From the ISSUE cycle: return Q in the first WAIT cycle, consume it.
   task automatic finish_op(input string tag, input logic [15:0] q);
      tick();
      bus.Q       = q;
      bus.out_val = 1'b1;
      tick();
      bus.out_val = 1'b0;
      check_eq({tag, "_r_valid"}, 16'(bus.r_valid), 16'd1);
      check_eq({tag, "_r_data"},  bus.r_data, q);
      bus.r_ready = 1'b1;
      tick();
      bus.r_ready = 1'b0;
      check_eq({tag, "_ready_back"}, 16'(bus.s_ready), 16'd1);
   endtask

   initial begin
      logic [15:0] tw [4];

      rst         = 1'b1;
      bus.s_data  = '0;
      bus.s_valid = 1'b0;
      bus.Q       = '0;
      bus.out_val = 1'b0;
      bus.r_ready = 1'b0;

      // ---- reset state ----
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_s_ready", 16'(bus.s_ready), 16'd0);
      check_eq("rst_in_val",  16'(bus.in_val),  16'd0);
      check_eq("rst_a",       bus.a,            16'd0);
      check_eq("rst_d",       bus.d,            16'd0);
      check_eq("rst_r_data",  bus.r_data,       16'd0);
      check_eq("rst_r_valid", 16'(bus.r_valid), 16'd0);
      check_eq("rst_timeout", 16'(bus.timeout), 16'd0);
      rst = 1'b0;
      tick();
      check_eq("rel_s_ready", 16'(bus.s_ready), 16'd1);

      // ---- held s_valid, Q = -7 three cycles after in_val, slow consumer ----
      c0 = inval_cnt;
      send4("t1", 16'd10, 16'd2, 16'd1, 16'd3);
      tick();
      check_eq("t1_w1_in_val",  16'(bus.in_val),  16'd0);
      check_eq("t1_w1_s_ready", 16'(bus.s_ready), 16'd0);
      tick();
      tick();
      bus.Q       = 16'hFFF9;
      bus.out_val = 1'b1;
      tick();
      bus.out_val = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check_eq("t1_r_valid", 16'(bus.r_valid), 16'd1);
         check_eq("t1_r_data",  bus.r_data,       16'hFFF9);
         check_eq("t1_s_ready", 16'(bus.s_ready), 16'd0);
         if (k < 4) tick();
      end
      bus.r_ready = 1'b1;
      tick();
      bus.r_ready = 1'b0;
      check_eq("t1_done_r_valid", 16'(bus.r_valid), 16'd0);
      check_eq("t1_done_s_ready", 16'(bus.s_ready), 16'd1);
      check_eq("t1_in_val_count", 16'(inval_cnt - c0), 16'd1);

      // ---- toggling s_valid, gaps not counted ----
      c0 = inval_cnt;
      tw[0] = 16'hFFFB; tw[1] = 16'd2; tw[2] = 16'd3; tw[3] = 16'd1;
      for (int i = 0; i < 4; i++) begin
         bus.s_data  = tw[i];
         bus.s_valid = 1'b1;
         tick();
         if (i < 3) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 16'h5A5A;
            tick();
            check_eq("t3_gap_s_ready", 16'(bus.s_ready), 16'd1);
         end
      end
      bus.s_valid = 1'b0;
      check_eq("t3_in_val", 16'(bus.in_val), 16'd1);
      check_eq("t3_a", bus.a, 16'hFFFB);
      check_eq("t3_b", bus.b, 16'd2);
      check_eq("t3_c", bus.c, 16'd3);
      check_eq("t3_d", bus.d, 16'd1);
      finish_op("t3", 16'h1234);
      check_eq("t3_in_val_count", 16'(inval_cnt - c0), 16'd1);

      // ---- out_val in COLLECT is ignored ----
      bus.Q       = 16'd99;
      bus.out_val = 1'b1;
      tick();
      bus.out_val = 1'b0;
      check_eq("t6_r_valid", 16'(bus.r_valid), 16'd0);
      check_eq("t6_s_ready", 16'(bus.s_ready), 16'd1);
      check_eq("t6_r_data",  bus.r_data,       16'h1234);
      check_eq("t6_in_val",  16'(bus.in_val),  16'd0);

      // ---- watchdog abort after 8 WAIT cycles ----
      c0 = tmo_cnt;
      send4("t4", 16'h0011, 16'h0022, 16'h0033, 16'h0044);
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("t4_wait_timeout", 16'(bus.timeout), 16'd0);
         check_eq("t4_wait_s_ready", 16'(bus.s_ready), 16'd0);
      end
      tick();
      check_eq("t4_timeout_pulse", 16'(bus.timeout), 16'd1);
      check_eq("t4_abort_s_ready", 16'(bus.s_ready), 16'd1);
      check_eq("t4_abort_r_valid", 16'(bus.r_valid), 16'd0);
      check_eq("t4_abort_a_hold",  bus.a,            16'h0011);
      tick();
      check_eq("t4_timeout_end",   16'(bus.timeout), 16'd0);
      check_eq("t4_timeout_count", 16'(tmo_cnt - c0), 16'd1);
      check_eq("t4_r_valid_low",   16'(bus.r_valid), 16'd0);

      // ---- new operation after abort; out_val on the last watchdog cycle ----
      c0 = tmo_cnt;
      send4("t4b", 16'd5, 16'd6, 16'd7, 16'd8);
      for (int k = 0; k < 8; k++) tick();
      check_eq("t4b_w8_state", 16'(bus.s_ready), 16'd0);
      bus.Q       = 16'h8000;
      bus.out_val = 1'b1;
      tick();
      bus.out_val = 1'b0;
      check_eq("t4b_r_valid", 16'(bus.r_valid), 16'd1);
      check_eq("t4b_r_data",  bus.r_data,       16'h8000);
      check_eq("t4b_timeout", 16'(bus.timeout), 16'd0);
      tick();
      check_eq("t4b_timeout_next", 16'(bus.timeout), 16'd0);
      check_eq("t4b_r_valid_hold", 16'(bus.r_valid), 16'd1);
      check_eq("t4b_no_pulse",     16'(tmo_cnt - c0), 16'd0);
      bus.r_ready = 1'b1;
      tick();
      bus.r_ready = 1'b0;
      check_eq("t4b_s_ready", 16'(bus.s_ready), 16'd1);

      // ---- reset mid-collection discards partial words ----
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h0077;
      tick();
      bus.s_data  = 16'h0088;
      tick();
      bus.s_valid = 1'b0;
      check_eq("t5_part_a", bus.a, 16'h0077);
      check_eq("t5_part_b", bus.b, 16'h0088);
      rst = 1'b1;
      #1;
      check_eq("t5_rst_a",       bus.a,            16'd0);
      check_eq("t5_rst_b",       bus.b,            16'd0);
      check_eq("t5_rst_s_ready", 16'(bus.s_ready), 16'd0);
      tick();
      rst = 1'b0;
      tick();
      check_eq("t5_rel_s_ready", 16'(bus.s_ready), 16'd1);
      send4("t5", 16'd1, 16'd1, 16'd1, 16'd1);
      finish_op("t5", 16'h7FFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/task1_feeder.md
# task1_feeder

Sequencer that sits directly upstream of `task1` and also collects its result. Accepts a serial stream of signed operand words over a valid/ready handshake, packs four consecutive words into `a`, `b`, `c`, `d`, and issues a single-cycle `in_val` to `task1`. It then waits for `out_val`, captures `Q`, and presents it on a valid/ready result port. It guarantees only one operation is in flight at a time, with a watchdog against a missing `out_val`.

## Interface
- `WIDTH`, 16: operand and result width, signed two's complement.
- `TIMEOUT`, 255: maximum WAIT cycles without `out_val` before abort; must be ≥ 1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_data`  in  WIDTH  signed operand word.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  feeder accepts a word this cycle.
- `in_val`  out  1  one-cycle start pulse to `task1`.
- `a`, `b`, `c`, `d`  out  WIDTH each  signed operands to `task1`.
- `Q`  in  WIDTH  signed result from `task1`.
- `out_val`  in  1  `Q` valid, from `task1`.
- `r_data`  out  WIDTH  captured signed result.
- `r_valid`  out  1  `r_data` valid.
- `r_ready`  in  1  result consumer accepts.
- `timeout`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States:
  - COLLECT: `s_ready` = 1. A word is accepted when `s_valid && s_ready` at an edge. Words fill `a`, `b`, `c`, `d` in order, tracked by a 2-bit index. Accepting the 4th word transitions to ISSUE.
  - ISSUE: `in_val` = 1 for exactly this cycle; `s_ready` = 0. Transitions to WAIT.
  - WAIT: `s_ready` = 0; the watchdog counter runs.
    - `out_val` high: capture `Q` into `r_data` and transition to RESULT.
    - `TIMEOUT` consecutive WAIT cycles without `out_val`: pulse `timeout`, transition to COLLECT with index 0, no result produced.
  - RESULT: `r_valid` = 1 and `r_data` held. On `r_valid && r_ready`, transition to COLLECT.
- Operand registers: `a`..`d` change only on word acceptance in COLLECT. They hold stable from ISSUE through the end of WAIT and keep their last values afterwards.
- `out_val` outside WAIT is ignored; no state or data change.
- No arithmetic is performed. `Q` is stored bit-exact, with sign preserved.
- The watchdog counter is wide enough for `TIMEOUT` (`$clog2(TIMEOUT+1)` bits). It clears on entry to WAIT.
- Reset, at any time including mid-collection or in WAIT/RESULT:
  - State returns to COLLECT, index to 0; partial words are discarded.
  - All outputs go to 0: `s_ready` = 0 during reset, then 1 on the first cycle after release; `in_val`, `a`–`d`, `r_data`, `r_valid`, `timeout` all 0.

## Timing
- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- 4th word accepted at edge N: `in_val` = 1 during cycle N..N+1, and the new `a`–`d` are visible from the same cycle.
- `out_val` sampled high at edge M in WAIT: `r_valid` = 1 and `r_data` = `Q` from cycle M onward.
- Result handshake completing at edge K: `r_valid` = 0 and `s_ready` = 1 from cycle K onward.
- Minimum operation period: 4 (collect) + 1 (issue) + `task1` latency + 1 (result) cycles.
- Simultaneous `out_val` and the final watchdog cycle: `out_val` wins; the result is captured and there is no `timeout` pulse.
- A `timeout` pulse lasts exactly one cycle, aligned with the first COLLECT cycle after the abort.

## Structure
- Shared package `task1_pkg`:
  - default `WIDTH`;
  - state encoding as a 2-bit enum {COLLECT, ISSUE, WAIT, RESULT};
  - operand index constants.
- Single module, no sub-module. The FSM, operand shift/index logic, watchdog and result register are small enough to sit together.

## Test plan
- Stream 10, 2, 1, 3 with `s_valid` held: `a`=10, `b`=2, `c`=1, `d`=3, and `in_val` high for exactly one cycle after the 4th accept. `s_ready` = 0 until the result is consumed.
- Stub `task1` returns `Q` = −7 three cycles after `in_val`, with `r_ready` = 0 for 5 cycles: `r_data` = −7 (0xFFF9) and `r_valid` held the full 5 cycles. `s_ready` returns the cycle after the handshake.
- Words −5, 2, 3, 1 with `s_valid` toggling every other cycle: `a`=−5, `b`=2, `c`=3, `d`=1; exactly one `in_val`, with gaps not counted as words.
- `TIMEOUT` = 8, stub never asserts `out_val`: `timeout` pulses once 8 WAIT cycles after ISSUE, `r_valid` stays 0, and the next 4 words start a new operation.
- Assert `rst` after 2 accepted words, then send 4 fresh words 1, 1, 1, 1: `a`–`d` all 1, and stale words never appear on `a`–`d`.
- `out_val` pulsed in COLLECT with `Q` = 99: no `r_valid` and no state change. Then `out_val` on the last watchdog cycle: result captured, no `timeout`.
